alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu.sv | 196 +++++++++++++++++++
 tb/tb_alu_mdu.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// alu_mdu: single-issue ALU with iterative multiply/divide unit.
// Build option: define ALU_MDU_DIV_EN to include the iterative divider.
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             equal,
  output logic             div_zero
);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opd;
  logic [SHW-1:0]   cnt;
  logic             neg_lo;
  logic             last;
  logic             accept;
  logic             is_mul;
  logic             is_mult;
  logic             is_div;
  logic             dz;
  logic [WIDTH-1:0] alu;
  logic [SHW-1:0]   sh;

  logic [WIDTH:0]     msum;
  logic [WIDTH-1:0]   m_hi;
  logic [WIDTH-1:0]   m_lo;
  logic [2*WIDTH-1:0] mprod;
  logic [2*WIDTH-1:0] mfin;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == SHW'(WIDTH - 1));
  assign sh        = y[SHW-1:0];
  assign is_mult   = (op == 5'd13);
  assign is_mul    = is_mult || (op == 5'd14);
  assign dz        = is_div && (y == '0);

`ifdef ALU_MDU_DIV_EN
  logic             is_sdiv;
  logic             neg_hi;
  logic [WIDTH:0]   dtry;
  logic [WIDTH-1:0] d_rem;
  logic [WIDTH-1:0] d_quo;

  assign is_sdiv = (op == 5'd15);
  assign is_div  = is_sdiv || (op == 5'd16);

  assign dtry  = {acc, lo[WIDTH-1]}
               - {1'b0, opd};
  assign d_rem = dtry[WIDTH]
               ? {acc[WIDTH-2:0], lo[WIDTH-1]}
               : dtry[WIDTH-1:0];
  assign d_quo = {lo[WIDTH-2:0], ~dtry[WIDTH]};
`else
  assign is_div = 1'b0;
`endif

  assign msum  = {1'b0, acc}
               + (lo[0] ? {1'b0, opd} : '0);
  assign m_hi  = msum[WIDTH:1];
  assign m_lo  = {msum[0], lo[WIDTH-1:1]};
  assign mprod = {m_hi, m_lo};
  assign mfin  = neg_lo ? -mprod : mprod;

  // single-cycle ALU result for the request at the input
  always_comb begin
    alu = '0;
    unique case (1'b1)
      op == 5'd0:  alu = x << sh;
      op == 5'd1:  alu = $signed(x) >>> sh;
      op == 5'd2:  alu = x >> sh;
      op == 5'd5:  alu = x + y;
      op == 5'd6:  alu = x - y;
      op == 5'd7:  alu = x & y;
      op == 5'd8:  alu = x | y;
      op == 5'd9:  alu = x ^ y;
      op == 5'd10: alu = ~(x | y);
      op == 5'd11:
        alu = {{(WIDTH-1){1'b0}},
               $signed(x) < $signed(y)};
      op == 5'd12:
        alu = {{(WIDTH-1){1'b0}}, x < y};
      default:     alu = '0;
    endcase
  end

  // control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // next-state selection
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (is_mul)           state_n = MUL;
          else if (is_div && !dz) state_n = DIV;
          else                  state_n = DONE;
        end
      end
      MUL:  if (last) state_n = DONE;
      DIV:  if (last) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      hi       <= '0;
      equal    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      opd      <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      neg_hi   <= 1'b0;
`endif
    end else if (accept) begin
      equal    <= (x == y);
      cnt      <= '0;
      result   <= alu;
      hi       <= '0;
      div_zero <= 1'b0;
      acc      <= '0;
      if (is_mul) begin
        lo     <= (is_mult && x[WIDTH-1]) ? -x : x;
        opd    <= (is_mult && y[WIDTH-1]) ? -y : y;
        neg_lo <= is_mult
               && (x[WIDTH-1] ^ y[WIDTH-1]);
      end
`ifdef ALU_MDU_DIV_EN
      if (is_div) begin
        if (dz) begin
          result   <= '1;
          hi       <= x;
          div_zero <= 1'b1;
        end
        lo     <= (is_sdiv && x[WIDTH-1]) ? -x : x;
        opd    <= (is_sdiv && y[WIDTH-1]) ? -y : y;
        neg_lo <= is_sdiv
               && (x[WIDTH-1] ^ y[WIDTH-1]);
        neg_hi <= is_sdiv && x[WIDTH-1];
      end
`endif
    end else if (state == MUL) begin
      acc <= m_hi;
      lo  <= m_lo;
      cnt <= cnt + SHW'(1);
      if (last) begin
        result <= mfin[WIDTH-1:0];
        hi     <= mfin[2*WIDTH-1:WIDTH];
      end
`ifdef ALU_MDU_DIV_EN
    end else if (state == DIV) begin
      acc <= d_rem;
      lo  <= d_quo;
      cnt <= cnt + SHW'(1);
      if (last) begin
        result <= neg_lo ? -d_quo : d_quo;
        hi     <= neg_hi ? -d_rem : d_rem;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed and random checks of alu_mdu (WIDTH=32)
// against a plain-arithmetic reference model.
module tb_alu_mdu;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] x;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [31:0] hi;
  logic        equal;
  logic        div_zero;

  int errors = 0;
  int checks = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .x(x),
    .y(y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .hi(hi),
    .equal(equal),
    .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic void model(
    input  logic [4:0]  o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] r,
    output logic [31:0] h,
    output logic        z,
    output int          lat);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    r = '0;
    h = '0;
    z = 1'b0;
    lat = 1;
    case (o)
      5'd0:  r = a << b[4:0];
      5'd1:  r = 32'(sa >>> b[4:0]);
      5'd2:  r = a >> b[4:0];
      5'd5:  r = a + b;
      5'd6:  r = a - b;
      5'd7:  r = a & b;
      5'd8:  r = a | b;
      5'd9:  r = a ^ b;
      5'd10: r = ~(a | b);
      5'd11: r = (sa < sb) ? 32'd1 : 32'd0;
      5'd12: r = (a < b) ? 32'd1 : 32'd0;
      5'd13: begin
        p = sa * sb;
        r = p[31:0];
        h = p[63:32];
        lat = 33;
      end
      5'd14: begin
        p = {32'b0, a} * {32'b0, b};
        r = p[31:0];
        h = p[63:32];
        lat = 33;
      end
`ifdef ALU_MDU_DIV_EN
      5'd15, 5'd16: begin
        if (b == 0) begin
          r = '1;
          h = a;
          z = 1'b1;
        end else if (o == 5'd15) begin
          r = 32'(sa / sb);
          h = 32'(sa % sb);
          lat = 33;
        end else begin
          r = a / b;
          h = a % b;
          lat = 33;
        end
      end
`endif
      default: ;
    endcase
  endfunction

  // one full transaction: accept, wait, hold, release
  task automatic txn(input logic [4:0]  o,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int          hold);
    logic [31:0] er;
    logic [31:0] eh;
    logic        ez;
    int          elat;
    int          lat;
    logic        busy_ok;
    logic        hold_ok;
    string       t;
    model(o, a, b, er, eh, ez, elat);
    t = $sformatf("op%0d x=%0h y=%0h", o, a, b);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = o;
    x = a;
    y = b;
    chk({t, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 5'($urandom);
    x = $urandom;
    y = $urandom;
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 100) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      x = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({t, " latency"}, 64'(lat), 64'(elat));
    chk({t, " busy"}, 64'(busy_ok), 64'd1);
    chk({t, " result"}, 64'(result), 64'(er));
    chk({t, " hi"}, 64'(hi), 64'(eh));
    chk({t, " equal"}, 64'(equal),
        64'(a == b));
    chk({t, " div_zero"}, 64'(div_zero),
        64'(ez));
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      op = 5'($urandom);
      x = $urandom;
      y = $urandom;
      @(posedge clk);
      #1;
      if (!(out_valid === 1'b1
            && in_ready === 1'b0
            && result === er && hi === eh
            && equal === (a == b)
            && div_zero === ez))
        hold_ok = 1'b0;
    end
    if (hold > 0)
      chk({t, " hold"}, 64'(hold_ok), 64'd1);
    @(negedge clk);
    in_valid = 1'b1;
    op = 5'd5;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk({t, " release"},
        {62'd0, out_valid, in_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset flags",
        {62'd0, equal, div_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready after reset",
        64'(in_ready), 64'd1);

    txn(5'd1, 32'h8000_0000, 32'd4, 0);
    txn(5'd13, 32'hFFFF_FFFD, 32'd7, 0);
    txn(5'd5, 32'hFFFF_FFFF, 32'd1, 5);
    txn(5'd13, 32'h8000_0000, 32'h8000_0000, 1);
    txn(5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    txn(5'd11, 32'h8000_0000, 32'd1, 0);
    txn(5'd12, 32'h8000_0000, 32'd1, 0);
    txn(5'd3, 32'h1234, 32'h1234, 0);
    txn(5'd20, 32'hFFFF, 32'h1, 0);
    txn(5'd15, 32'd9, 32'd3, 0);
    txn(5'd15, 32'hFFFF_FFF9, 32'd2, 2);
    txn(5'd16, 32'd5, 32'd0, 0);
    txn(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    txn(5'd15, 32'd7, 32'hFFFF_FFFE, 0);

    // reset in the middle of a MULTU
    @(negedge clk);
    in_valid = 1'b1;
    op = 5'd14;
    x = 32'hDEAD_BEEF;
    y = 32'h1234_5678;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst mid out_valid", 64'(out_valid), 64'd0);
    chk("rst mid in_ready", 64'(in_ready), 64'd1);
    chk("rst mid result", 64'(result), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("no result after reset",
        64'(out_valid), 64'd0);
    txn(5'd14, 32'hFFFF_FFFF, 32'd2, 0);

    for (int n = 0; n < 40; n++) begin
      logic [4:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 5'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = ra;
        default: ;
      endcase
      if (n % 4 == 0) ro = 5'd13 + 5'(n % 16 / 4);
      txn(ro, ra, rb, $urandom_range(3));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
